// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM command responder: command and state
// encodings, default service times and a small compile-time helper.
package dram_pkg;

    typedef enum logic [1:0] {
        CMD_ACT = 2'b00,
        CMD_RD  = 2'b01,
        CMD_WR  = 2'b10,
        CMD_PRE = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        ACK  = 2'b10
    } state_e;

    localparam int unsigned T_RCD = 3;
    localparam int unsigned T_CL  = 2;
    localparam int unsigned T_WR  = 2;
    localparam int unsigned T_RP  = 3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dram_onehot_enc.sv
// One-hot to binary encoder with a one-hot validity flag.
// A zero input encodes to index 0 and is flagged as not one-hot.
module dram_onehot_enc #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] onehot,
    output logic [IW-1:0]    idx,
    output logic             is_onehot
);

    // OR together the indices of every set bit; exact for a one-hot input
    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (onehot[i]) begin
                idx = idx | IW'(i);
            end
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero
    always_comb begin
        is_onehot = (onehot != '0) && ((onehot & (onehot - WIDTH'(1))) == '0);
    end

endmodule

// File: rtl/dram_cmd_responder.sv
// Device-side responder for the cmd_req/cmd_ack four-phase handshake.
// Captures and checks a command in IDLE, times it out in EXEC, pulses the
// array/row-buffer strobe on the last service cycle and then acknowledges.
module dram_cmd_responder
    import dram_pkg::*;
#(
    parameter int unsigned NUM_OF_BANKS = 8,
    parameter int unsigned NUM_OF_ROWS  = 128,
    parameter int unsigned NUM_OF_COLS  = 8,
    parameter int unsigned T_RCD        = dram_pkg::T_RCD,
    parameter int unsigned T_CL         = dram_pkg::T_CL,
    parameter int unsigned T_WR         = dram_pkg::T_WR,
    parameter int unsigned T_RP         = dram_pkg::T_RP
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cmd_req,
    input  logic [1:0]                      cmd,
    input  logic [NUM_OF_BANKS-1:0]         bank_sel,
    input  logic [NUM_OF_ROWS-1:0]          row_sel,
    input  logic [NUM_OF_COLS-1:0]          col_sel,
    output logic                            cmd_ack,
    output logic                            cmd_err,
    output logic [$clog2(NUM_OF_BANKS)-1:0] bank_id,
    output logic [$clog2(NUM_OF_ROWS)-1:0]  row_id,
    output logic [$clog2(NUM_OF_COLS)-1:0]  col_id,
    output logic                            bank_en,
    output logic                            bank_rw,
    output logic                            buf_en,
    output logic                            buf_rw,
    output logic [NUM_OF_BANKS-1:0]         open_vld
);

    localparam int unsigned BW    = $clog2(NUM_OF_BANKS);
    localparam int unsigned RW    = $clog2(NUM_OF_ROWS);
    localparam int unsigned CW    = $clog2(NUM_OF_COLS);
    localparam int unsigned T_MAX = max_u(max_u(T_RCD, T_CL), max_u(T_WR, T_RP));
    localparam int unsigned CNTW  = $clog2(T_MAX + 1);

    state_e          state;
    state_e          state_nxt;
    cmd_e            cmd_q;
    cmd_e            cmd_in;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] svc_load;
    logic            err_q;
    logic            legal;
    logic            fire;
    logic [RW-1:0]   open_row [NUM_OF_BANKS];

    logic [BW-1:0]   bank_idx;
    logic [RW-1:0]   row_idx;
    logic [CW-1:0]   col_idx;
    logic            bank_oh;
    logic            row_oh;
    logic            col_oh;

    dram_onehot_enc #(.WIDTH(NUM_OF_BANKS), .IW(BW)) u_bank_enc (
        .onehot    (bank_sel),
        .idx       (bank_idx),
        .is_onehot (bank_oh)
    );

    dram_onehot_enc #(.WIDTH(NUM_OF_ROWS), .IW(RW)) u_row_enc (
        .onehot    (row_sel),
        .idx       (row_idx),
        .is_onehot (row_oh)
    );

    dram_onehot_enc #(.WIDTH(NUM_OF_COLS), .IW(CW)) u_col_enc (
        .onehot    (col_sel),
        .idx       (col_idx),
        .is_onehot (col_oh)
    );

    assign cmd_in = cmd_e'(cmd);
    assign fire   = (state == EXEC) && (cnt == '0);

    // Legality of the presented command against the open-row table
    always_comb begin
        legal = 1'b0;
        if (bank_oh) begin
            case (cmd_in)
                CMD_ACT: legal = row_oh && !open_vld[bank_idx];
                CMD_RD,
                CMD_WR:  legal = row_oh && col_oh && open_vld[bank_idx]
                                 && (open_row[bank_idx] == row_idx);
                CMD_PRE: legal = 1'b1;
                default: legal = 1'b0;
            endcase
        end
    end

    // Counter preload: service time minus one, so EXEC lasts exactly T_x cycles
    always_comb begin
        svc_load = '0;
        case (cmd_in)
            CMD_ACT: svc_load = CNTW'(T_RCD - 1);
            CMD_RD:  svc_load = CNTW'(T_CL - 1);
            CMD_WR:  svc_load = CNTW'(T_WR - 1);
            CMD_PRE: svc_load = CNTW'(T_RP - 1);
            default: svc_load = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for the handshake FSM
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_req) begin
                    state_nxt = legal ? EXEC : ACK;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                if (!cmd_req) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command capture, service counter, error flag and open-row table
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q    <= CMD_ACT;
            bank_id  <= '0;
            row_id   <= '0;
            col_id   <= '0;
            cnt      <= '0;
            err_q    <= 1'b0;
            open_vld <= '0;
            for (int unsigned i = 0; i < NUM_OF_BANKS; i++) begin
                open_row[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_req) begin
                        cmd_q   <= cmd_in;
                        bank_id <= bank_idx;
                        row_id  <= row_idx;
                        col_id  <= col_idx;
                        err_q   <= !legal;
                        cnt     <= legal ? svc_load : '0;
                    end
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNTW'(1);
                    end else if (cmd_q == CMD_ACT) begin
                        open_vld[bank_id] <= 1'b1;
                        open_row[bank_id] <= row_id;
                    end else if (cmd_q == CMD_PRE) begin
                        open_vld[bank_id] <= 1'b0;
                    end
                end
                ACK: begin
                    if (!cmd_req) begin
                        err_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Acknowledge and one-cycle strobes; PRE to a closed bank times out silently
    always_comb begin
        cmd_ack = (state == ACK);
        cmd_err = err_q;
        bank_en = 1'b0;
        bank_rw = 1'b0;
        buf_en  = 1'b0;
        buf_rw  = 1'b0;
        if (fire) begin
            case (cmd_q)
                CMD_ACT: begin
                    bank_en = 1'b1;
                    bank_rw = 1'b1;
                end
                CMD_PRE: begin
                    bank_en = open_vld[bank_id];
                end
                CMD_RD: begin
                    buf_en = 1'b1;
                    buf_rw = 1'b1;
                end
                CMD_WR: begin
                    buf_en = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
